// File: rtl/cpu_control.sv
// -----------------------------------------------------------------------------
// cpu_control
//
// Top-level sequencer for the multi-cycle CPU. Each instruction is stepped
// through FETCH -> DECODE -> ALU -> (MEM) -> WB by pulsing exactly one stage
// enable per completed step. The controller also owns the single memory bus
// (instruction fetch vs. data access), watches for bus timeouts and services
// debug halt requests.
//
// Parameters:
//   TIMEOUT      max wait cycles for mem_ack before a bus error is raised
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   mem_op_next  from ALU stage: current instruction needs a memory access
//   mem_ack      memory bus: current request completes this cycle
//   halt_req     debug halt request
//   mem_req      request to the memory bus
//   bus_sel      bus owner, 0 = instruction fetch, 1 = data access
//   fetch_en     one-cycle enable, fetch stage
//   decode_en    one-cycle enable, decode stage
//   alu_en       one-cycle enable, ALU stage
//   mem_en       one-cycle enable, memory stage
//   wb_en        one-cycle enable, writeback stage
//   halted       controller is in HALT
//   bus_error    sticky bus-timeout flag, cleared only by reset
//   instr_count  retired instruction counter (wraps silently)
//   dbg_state    current state encoding
// -----------------------------------------------------------------------------
module cpu_control #(
   parameter logic [7:0] TIMEOUT = 8'd200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_op_next,
   input  logic        mem_ack,
   input  logic        halt_req,
   output logic        mem_req,
   output logic        bus_sel,
   output logic        fetch_en,
   output logic        decode_en,
   output logic        alu_en,
   output logic        mem_en,
   output logic        wb_en,
   output logic        halted,
   output logic        bus_error,
   output logic [15:0] instr_count,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      ALU    = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } stateT;

   stateT       state;
   logic [7:0]  waitCnt;
   logic [15:0] instrCount;
   logic        busError;

   // ---------------------------------------------------------------------------
   // Sequencer. waitCnt counts cycles a bus request has gone unanswered; it is
   // cleared on every entry into FETCH/MEM and on every ack so each access
   // starts its own timeout window. An ack in the timeout cycle still wins.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FETCH;
         waitCnt    <= 8'd0;
         instrCount <= 16'd0;
         busError   <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (mem_ack) begin
                  state   <= DECODE;
                  waitCnt <= 8'd0;
               end else if (waitCnt == TIMEOUT) begin
                  busError <= 1'b1;
                  state    <= HALT;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            DECODE: begin
               state <= ALU;
            end
            ALU: begin
               // mem_op_next is only meaningful while the ALU stage is enabled
               state   <= mem_op_next ? MEM : WB;
               waitCnt <= 8'd0;
            end
            MEM: begin
               if (mem_ack) begin
                  state   <= WB;
                  waitCnt <= 8'd0;
               end else if (waitCnt == TIMEOUT) begin
                  busError <= 1'b1;
                  state    <= HALT;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            WB: begin
               instrCount <= instrCount + 16'd1;
               // halt requests only take effect at an instruction boundary
               state      <= halt_req ? HALT : FETCH;
               waitCnt    <= 8'd0;
            end
            HALT: begin
               // a bus error pins the controller here until reset
               if (!halt_req && !busError) begin
                  state   <= FETCH;
                  waitCnt <= 8'd0;
               end
            end
            default: begin
               state   <= FETCH;
               waitCnt <= 8'd0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output decode from the registered state. fetch_en/mem_en follow mem_ack
   // in the same cycle. While reset is asserted every strobe is held low so no
   // stage sees a spurious enable or bus request during the reset cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_req   = 1'b0;
      bus_sel   = 1'b0;
      fetch_en  = 1'b0;
      decode_en = 1'b0;
      alu_en    = 1'b0;
      mem_en    = 1'b0;
      wb_en     = 1'b0;
      halted    = 1'b0;
      if (!reset) begin
         case (state)
            FETCH: begin
               mem_req  = 1'b1;
               fetch_en = mem_ack;
            end
            DECODE: decode_en = 1'b1;
            ALU:    alu_en    = 1'b1;
            MEM: begin
               mem_req = 1'b1;
               bus_sel = 1'b1;
               mem_en  = mem_ack;
            end
            WB:     wb_en     = 1'b1;
            HALT:   halted    = 1'b1;
            default: ;
         endcase
      end
   end

   assign bus_error   = busError;
   assign instr_count = instrCount;
   assign dbg_state   = state;

endmodule

// File: tb/tb_cpu_control.sv
// -----------------------------------------------------------------------------
// tb_cpu_control
//
// Randomized scoreboard bench for cpu_control. Instructions are described at
// the transaction level (fetch wait cycles, memory op, data wait cycles, halt
// and halt hold time); the driver expands each one into the cycle-by-cycle
// outputs the sequencer must show and queues them. An independent monitor
// samples the DUT every cycle and pops/compares.
// -----------------------------------------------------------------------------
module tb_cpu_control;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_op_next;
   logic        mem_ack;
   logic        halt_req;
   logic        mem_req;
   logic        bus_sel;
   logic        fetch_en;
   logic        decode_en;
   logic        alu_en;
   logic        mem_en;
   logic        wb_en;
   logic        halted;
   logic        bus_error;
   logic [15:0] instr_count;
   logic [2:0]  dbg_state;

   always #5 clk = ~clk;

   cpu_control #(.TIMEOUT(8'd4)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_op_next(mem_op_next),
      .mem_ack    (mem_ack),
      .halt_req   (halt_req),
      .mem_req    (mem_req),
      .bus_sel    (bus_sel),
      .fetch_en   (fetch_en),
      .decode_en  (decode_en),
      .alu_en     (alu_en),
      .mem_en     (mem_en),
      .wb_en      (wb_en),
      .halted     (halted),
      .bus_error  (bus_error),
      .instr_count(instr_count),
      .dbg_state  (dbg_state)
   );

   localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_A = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;
   // enable vector order: {fetch, decode, alu, mem, wb}
   localparam logic [4:0] EN_0 = 5'b00000, EN_F = 5'b10000, EN_D = 5'b01000,
                          EN_A = 5'b00100, EN_M = 5'b00010, EN_W = 5'b00001;

   typedef struct packed {
      logic [2:0]  st;
      logic [4:0]  en;
      logic        req;
      logic        sel;
      logic        hlt;
      logic        err;
      logic [15:0] cnt;
   } expT;

   expT         expQ[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] expCount = 16'd0;
   logic        expErr = 1'b0;
   int          instrNo = 0;

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock cycle of stimulus plus the outputs that cycle must show.
   task automatic cyc(input logic rst, input logic ack, input logic opn, input logic hreq,
                      input logic [2:0] st, input logic [4:0] en,
                      input logic req, input logic sel, input logic hlt);
      expT e;
      @(negedge clk);
      reset       = rst;
      mem_ack     = ack;
      mem_op_next = opn;
      halt_req    = hreq;
      e.st  = st;
      e.en  = en;
      e.req = req;
      e.sel = sel;
      e.hlt = hlt;
      e.err = expErr;
      e.cnt = expCount;
      expQ.push_back(e);
   endtask

   // Reset cycle: strobes low, registers still hold their pre-reset values.
   task automatic doReset(input logic [2:0] curSt);
      cyc(1'b1, rb(), rb(), rb(), curSt, EN_0, 1'b0, 1'b0, 1'b0);
      expErr   = 1'b0;
      expCount = 16'd0;
   endtask

   // One complete instruction described at transaction level.
   task automatic runInstr(input int fw, input bit memop, input int mw,
                           input bit halt, input int holdLen);
      for (int i = 0; i < fw; i++) cyc(1'b0, 1'b0, rb(), rb(), S_F, EN_0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, rb(), rb(), S_F, EN_F, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, rb(), rb(), rb(), S_D, EN_D, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, rb(), memop, rb(), S_A, EN_A, 1'b0, 1'b0, 1'b0);
      if (memop) begin
         for (int i = 0; i < mw; i++) cyc(1'b0, 1'b0, rb(), rb(), S_M, EN_0, 1'b1, 1'b1, 1'b0);
         cyc(1'b0, 1'b1, rb(), rb(), S_M, EN_M, 1'b1, 1'b1, 1'b0);
      end
      cyc(1'b0, rb(), rb(), halt, S_W, EN_W, 1'b0, 1'b0, 1'b0);
      expCount = expCount + 16'd1;
      if (halt) begin
         for (int i = 0; i < holdLen; i++) cyc(1'b0, rb(), rb(), 1'b1, S_H, EN_0, 1'b0, 1'b0, 1'b1);
         cyc(1'b0, rb(), rb(), 1'b0, S_H, EN_0, 1'b0, 1'b0, 1'b1);
      end
      instrNo++;
      $display("instr %0d: fetchWait=%0d memOp=%0d memWait=%0d halt=%0d hold=%0d retired=%0d",
               instrNo, fw, memop, mw, halt, holdLen, expCount);
   endtask

   // Bus left unanswered: five request cycles, then HALT with the sticky
   // error; dropping halt_req must not release it; only reset does.
   task automatic timeoutTest(input bit inMem);
      logic [2:0] st;
      st = inMem ? S_M : S_F;
      if (inMem) begin
         cyc(1'b0, 1'b1, rb(), rb(), S_F, EN_F, 1'b1, 1'b0, 1'b0);
         cyc(1'b0, rb(), rb(), rb(), S_D, EN_D, 1'b0, 1'b0, 1'b0);
         cyc(1'b0, rb(), 1'b1, rb(), S_A, EN_A, 1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, rb(), rb(), st, EN_0, 1'b1, inMem, 1'b0);
      expErr = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1'b0, rb(), rb(), 1'b0, S_H, EN_0, 1'b0, 1'b0, 1'b1);
      doReset(S_H);
      $display("timeout in %s: bus error raised and cleared by reset", inMem ? "MEM" : "FETCH");
   endtask

   task automatic preloadCount();
      @(posedge clk);
      #1;
      force dut.instrCount = 16'hFFFF;
      #1;
      release dut.instrCount;
      expCount = 16'hFFFF;
   endtask

   // Monitor: checks every queued cycle independently of the driver.
   initial begin
      expT e;
      expT got;
      forever begin
         @(negedge clk);
         #2;
         if (expQ.size() > 0) begin
            e   = expQ.pop_front();
            got.st  = dbg_state;
            got.en  = {fetch_en, decode_en, alu_en, mem_en, wb_en};
            got.req = mem_req;
            got.sel = bus_sel;
            got.hlt = halted;
            got.err = bus_error;
            got.cnt = instr_count;
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL cycle t=%0t: got st=%0d en=%b req=%b sel=%b hlt=%b err=%b cnt=%h, required st=%0d en=%b req=%b sel=%b hlt=%b err=%b cnt=%h",
                        $time, got.st, got.en, got.req, got.sel, got.hlt, got.err, got.cnt,
                        e.st, e.en, e.req, e.sel, e.hlt, e.err, e.cnt);
            end
         end
      end
   end

   initial begin
      reset       = 1'b1;
      mem_ack     = 1'b0;
      mem_op_next = 1'b0;
      halt_req    = 1'b0;
      @(posedge clk);
      doReset(S_F);

      // zero-wait ALU-only stream
      for (int i = 0; i < 3; i++) runInstr(0, 1'b0, 0, 1'b0, 0);
      // data access with three wait states (8 cycles)
      runInstr(0, 1'b1, 3, 1'b0, 0);
      // halt at instruction boundary, held then released
      runInstr(0, 1'b0, 0, 1'b1, 2);
      // ack arriving exactly on the timeout cycle
      runInstr(4, 1'b1, 4, 1'b0, 0);
      // timeouts
      timeoutTest(1'b0);
      runInstr(1, 1'b0, 0, 1'b0, 0);
      timeoutTest(1'b1);

      // counter wrap
      runInstr(0, 1'b0, 0, 1'b0, 0);
      preloadCount();
      runInstr(0, 1'b1, 1, 1'b0, 0);
      runInstr(0, 1'b0, 0, 1'b0, 0);

      // reset while a data access is pending
      cyc(1'b0, 1'b1, rb(), rb(), S_F, EN_F, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, rb(), rb(), rb(), S_D, EN_D, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, rb(), 1'b1, rb(), S_A, EN_A, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, rb(), rb(), S_M, EN_0, 1'b1, 1'b1, 1'b0);
      doReset(S_M);
      cyc(1'b0, 1'b0, rb(), rb(), S_F, EN_0, 1'b1, 1'b0, 1'b0);
      runInstr(2, 1'b0, 0, 1'b0, 0);

      // randomized instruction mix
      for (int n = 0; n < 60; n++) begin
         int fw;
         int mw;
         fw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : 0;
         mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : 0;
         runInstr(fw, rb(), mw, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)));
      end

      repeat (2) @(negedge clk);
      #3;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d pending entries, required 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
